// File: rtl/weight_arbiter_rr_pkg.sv
// weight_arb_pkg: shared state encoding, mode constants and width helper for the weight arbiter
package weight_arb_pkg;
  typedef enum logic [1:0] {IDLE, PICK, BUSY, FIN} arb_state_t;
  localparam bit MODE_RR    = 1'b1;
  localparam bit MODE_FIXED = 1'b0;
  function automatic int wd_width(input int cyc);
    return $clog2(cyc + 1);
  endfunction
endpackage

// File: rtl/weight_arbiter_rr_if.sv
// weight_arbiter_rr_if: handshake bundle between the arbiter and the shared weight loader
interface weight_arbiter_rr_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 17,
  parameter int DATA_W = 128
);
  logic              ldr_start;
  logic [ADDR_W-1:0] ldr_base;
  logic [CNT_W-1:0]  ldr_count;
  logic              ldr_valid;
  logic [DATA_W-1:0] ldr_data;
  logic              ldr_done;
  modport master (output ldr_start, ldr_base, ldr_count, input ldr_valid, ldr_data, ldr_done);
  modport slave  (input ldr_start, ldr_base, ldr_count, output ldr_valid, ldr_data, ldr_done);
endinterface

// File: rtl/weight_arbiter_rr_pick.sv
// rr_pick: combinational winner select, round-robin from last+1 or fixed lowest-index first
module rr_pick #(
  parameter int N_CH = 2
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] last,
  input  logic                    rr_en,
  output logic [N_CH-1:0]         oh,
  output logic [$clog2(N_CH)-1:0] idx
);
  int   c;
  logic found;
  always_comb begin
    oh = '0;
    idx = '0;
    found = 1'b0;
    c = 0;
    for (int k = 0; k < N_CH; k++) begin
      c = rr_en ? (int'(last) + 1 + k) % N_CH : k;
      if (!found && req[c]) begin
        found = 1'b1;
        oh[c] = 1'b1;
        idx = c[$clog2(N_CH)-1:0];
      end
    end
  end
endmodule

// File: rtl/weight_arbiter_rr.sv
// weight_arbiter_rr: shares one weight loader among N_CH consumers with zero-count bypass and stall watchdog
module weight_arbiter_rr
  import weight_arb_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 17,
  parameter int DATA_W      = 128,
  parameter int RR_EN       = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH*ADDR_W-1:0]   base,
  input  logic [N_CH*CNT_W-1:0]    count,
  output logic [N_CH-1:0]          grant,
  output logic [N_CH-1:0]          valid,
  output logic [DATA_W-1:0]        data,
  output logic [N_CH-1:0]          done,
  output logic [N_CH-1:0]          err,
  output logic                     busy,
  weight_arbiter_rr_if.master      ldr
);
  localparam int IW   = $clog2(N_CH);
  localparam int WD_W = wd_width(TIMEOUT_CYC);
  arb_state_t        state;
  logic [N_CH-1:0]   req_q;
  logic [IW-1:0]     last;
  logic [IW-1:0]     win;
  logic [N_CH-1:0]   pk_oh;
  logic [IW-1:0]     pk_idx;
  logic [CNT_W-1:0]  sel_cnt;
  logic [ADDR_W-1:0] sel_base;
  logic [WD_W-1:0]   wd;
  logic              zc;
  logic              tmo;
  rr_pick #(.N_CH(N_CH)) u_pick (
    .req   (req_q),
    .last  (last),
    .rr_en (RR_EN == int'(MODE_RR)),
    .oh    (pk_oh),
    .idx   (pk_idx)
  );
  assign sel_cnt  = count[pk_idx*CNT_W +: CNT_W];
  assign sel_base = base[pk_idx*ADDR_W +: ADDR_W];
  assign tmo      = wd == WD_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_q <= '0;
      last <= IW'(N_CH - 1);
      win <= '0;
      grant <= '0;
      valid <= '0;
      data <= '0;
      done <= '0;
      err <= '0;
      busy <= 1'b0;
      ldr.ldr_start <= 1'b0;
      ldr.ldr_base <= '0;
      ldr.ldr_count <= '0;
      wd <= '0;
      zc <= 1'b0;
    end else begin
      ldr.ldr_start <= 1'b0;
      valid <= '0;
      done <= '0;
      err <= '0;
      case (state)
        IDLE: if (|req) begin
          state <= PICK;
          req_q <= req;
          busy <= 1'b1;
        end
        PICK: begin
          grant <= pk_oh;
          win <= pk_idx;
          ldr.ldr_base <= sel_base;
          ldr.ldr_count <= sel_cnt;
          ldr.ldr_start <= sel_cnt != '0;
          zc <= sel_cnt == '0;
          wd <= '0;
          state <= sel_cnt == '0 ? FIN : BUSY;
        end
        BUSY: begin
          if (ldr.ldr_valid) begin
            data <= ldr.ldr_data;
            valid <= grant;
          end
          wd <= ldr.ldr_valid ? '0 : wd + WD_W'(1);
          if (ldr.ldr_done || (tmo && !ldr.ldr_valid)) begin
            state <= FIN;
            done <= grant;
            err <= ldr.ldr_done ? '0 : grant;
          end
        end
        default: begin
          done <= zc ? grant : '0;
          grant <= '0;
          last <= win;
          busy <= 1'b0;
          zc <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_weight_arbiter_rr.sv
// tb_weight_arbiter_rr: round-robin and fixed-priority arbiters on shared stimulus, table jobs plus corner sequences
module tb_weight_arbiter_rr;
  localparam int N = 4, AW = 16, CW = 8, DW = 32, TO = 16;
  typedef struct {
    logic [3:0] rq;
    logic [7:0] cnt;
    int         beats;
    bit         wl;
    logic [3:0] erw;
    logic [3:0] efx;
  } vec_t;
  typedef struct {
    logic [3:0]  ch;
    logic [31:0] d;
  } beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*AW-1:0] base = {16'hA303, 16'hA202, 16'hA101, 16'hA000};
  logic [N*CW-1:0] count = '0;
  logic lv = 1'b0, ld = 1'b0;
  logic [DW-1:0] ldat = '0;
  logic [N-1:0] gb, vb, db, eb, gc, vc, dc, ec;
  logic [DW-1:0] datb, datc;
  logic bb, bc;
  int pass = 0, total = 0;
  beat_t qb[$], qc[$];
  beat_t eb_m, ec_m;
  vec_t vt[11];
  weight_arbiter_rr_if #(.ADDR_W(AW), .CNT_W(CW), .DATA_W(DW)) ib ();
  weight_arbiter_rr_if #(.ADDR_W(AW), .CNT_W(CW), .DATA_W(DW)) ic ();
  assign ib.ldr_valid = lv;
  assign ib.ldr_data  = ldat;
  assign ib.ldr_done  = ld;
  assign ic.ldr_valid = lv;
  assign ic.ldr_data  = ldat;
  assign ic.ldr_done  = ld;
  weight_arbiter_rr #(.N_CH(N), .ADDR_W(AW), .CNT_W(CW), .DATA_W(DW), .RR_EN(1), .TIMEOUT_CYC(TO)) u_rr (
    .clk(clk), .rst(rst), .req(req), .base(base), .count(count), .grant(gb), .valid(vb),
    .data(datb), .done(db), .err(eb), .busy(bb), .ldr(ib)
  );
  weight_arbiter_rr #(.N_CH(N), .ADDR_W(AW), .CNT_W(CW), .DATA_W(DW), .RR_EN(0), .TIMEOUT_CYC(TO)) u_fx (
    .clk(clk), .rst(rst), .req(req), .base(base), .count(count), .grant(gc), .valid(vc),
    .data(datc), .done(dc), .err(ec), .busy(bc), .ldr(ic)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  function automatic logic [15:0] base_of(input logic [3:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return 16'hA000 + 16'(i) * 16'h0101;
    return 16'h0;
  endfunction
  always @(negedge clk) if (vb !== '0) begin
    if (qb.size() == 0) chk("rr_unexpected_valid", vb, 0);
    else begin
      eb_m = qb.pop_front();
      chk("rr_valid", vb, eb_m.ch);
      chk("rr_data", datb, eb_m.d);
    end
  end
  always @(negedge clk) if (vc !== '0) begin
    if (qc.size() == 0) chk("fx_unexpected_valid", vc, 0);
    else begin
      ec_m = qc.pop_front();
      chk("fx_valid", vc, ec_m.ch);
      chk("fx_data", datc, ec_m.d);
    end
  end
  task automatic zero_chk(input string n);
    chk({n, "_rr"}, {gb, vb, db, eb, bb, ib.ldr_start, datb, ib.ldr_base, ib.ldr_count}, '0);
    chk({n, "_fx"}, {gc, vc, dc, ec, bc, ic.ldr_start, datc, ic.ldr_base, ic.ldr_count}, '0);
  endtask
  task automatic push_beat(input logic [3:0] erw, input logic [3:0] efx);
    ldat = $urandom();
    qb.push_back('{erw, ldat});
    qc.push_back('{efx, ldat});
  endtask
  task automatic start_job(input logic [3:0] rq, input logic [7:0] cnt, input logic [3:0] erw, input logic [3:0] efx);
    req = rq;
    count = {N{cnt}};
    @(negedge clk);
    chk("pick_busy", {bb, bc, gb, gc}, {2'b11, 8'h00});
    @(negedge clk);
    chk("grant_rr", gb, erw);
    chk("grant_fx", gc, efx);
    chk("start", {ib.ldr_start, ic.ldr_start}, {2{cnt != 8'd0}});
    chk("base_rr", ib.ldr_base, base_of(erw));
    chk("base_fx", ic.ldr_base, base_of(efx));
    chk("count", {ib.ldr_count, ic.ldr_count}, {cnt, cnt});
  endtask
  task automatic finish_job(input int beats, input bit wl, input logic [3:0] erw, input logic [3:0] efx);
    for (int k = 0; k < beats; k++) begin
      lv = 1'b1;
      ld = wl && k == beats - 1;
      push_beat(erw, efx);
      @(negedge clk);
      if (k == 0) chk("start_one_cycle", {ib.ldr_start, ic.ldr_start}, 2'b00);
    end
    lv = 1'b0;
    if (!wl) begin
      ld = 1'b1;
      @(negedge clk);
    end
    ld = 1'b0;
    chk("done_rr", {db, eb}, {erw, 4'h0});
    chk("done_fx", {dc, ec}, {efx, 4'h0});
    @(negedge clk);
    chk("back_idle", {gb, gc, db, dc, bb, bc}, '0);
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int n;
    vt[0]  = '{4'b1111, 8'd1, 1, 1'b1, 4'b0001, 4'b0001};
    vt[1]  = '{4'b1111, 8'd1, 1, 1'b1, 4'b0010, 4'b0001};
    vt[2]  = '{4'b1111, 8'd1, 1, 1'b1, 4'b0100, 4'b0001};
    vt[3]  = '{4'b1111, 8'd1, 1, 1'b1, 4'b1000, 4'b0001};
    vt[4]  = '{4'b1111, 8'd1, 1, 1'b1, 4'b0001, 4'b0001};
    vt[5]  = '{4'b0001, 8'd4, 4, 1'b0, 4'b0001, 4'b0001};
    vt[6]  = '{4'b1010, 8'd2, 2, 1'b0, 4'b0010, 4'b0010};
    vt[7]  = '{4'b1010, 8'd2, 2, 1'b0, 4'b1000, 4'b0010};
    vt[8]  = '{4'b1010, 8'd2, 2, 1'b0, 4'b0010, 4'b0010};
    vt[9]  = '{4'b0010, 8'd0, 0, 1'b0, 4'b0010, 4'b0010};
    vt[10] = '{4'b0100, 8'd3, 3, 1'b1, 4'b0100, 4'b0100};
    repeat (3) @(negedge clk);
    zero_chk("reset");
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      start_job(vt[i].rq, vt[i].cnt, vt[i].erw, vt[i].efx);
      if (vt[i].cnt == 8'd0) begin
        @(negedge clk);
        chk("zero_done", {db, eb, dc, ec, gb, gc, ib.ldr_start, ic.ldr_start},
            {vt[i].erw, 4'h0, vt[i].efx, 4'h0, 8'h00, 2'b00});
      end else finish_job(vt[i].beats, vt[i].wl, vt[i].erw, vt[i].efx);
    end
    start_job(4'b1000, 8'd5, 4'b1000, 4'b1000);
    lv = 1'b1;
    push_beat(4'b1000, 4'b1000);
    @(negedge clk);
    lv = 1'b0;
    n = 1;
    while (db == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wd_latency", n, 17);
    chk("wd_done_err", {db, eb, dc, ec}, {4'b1000, 4'b1000, 4'b1000, 4'b1000});
    req = '0;
    ld = 1'b1;
    @(negedge clk);
    chk("late_done_1", {db, dc, bb, bc, gb, gc}, '0);
    @(negedge clk);
    chk("late_done_2", {db, dc, vb, vc, bb, bc}, '0);
    ld = 1'b0;
    start_job(4'b0100, 8'd4, 4'b0100, 4'b0100);
    lv = 1'b1;
    push_beat(4'b0100, 4'b0100);
    @(negedge clk);
    lv = 1'b0;
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    zero_chk("rst_mid");
    rst = 1'b0;
    lv = 1'b1;
    ld = 1'b1;
    ldat = $urandom();
    @(negedge clk);
    chk("stale_1", {vb, vc, db, dc, bb, bc}, '0);
    @(negedge clk);
    chk("stale_2", {vb, vc, db, dc, bb, bc}, '0);
    lv = 1'b0;
    ld = 1'b0;
    start_job(4'b1111, 8'd1, 4'b0001, 4'b0001);
    finish_job(1, 1'b1, 4'b0001, 4'b0001);
    chk("sb_empty_rr", qb.size(), 0);
    chk("sb_empty_fx", qc.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/weight_arbiter_rr.md
# weight_arbiter_rr

Parametrised N-channel arbiter that shares one weight loader between any number of weight consumers (DW cache, PW/CONV scheduler, future FC or bias fetchers). It grants one channel at a time, round-robin or fixed priority, and forwards that channel's base and count to the loader as a one-cycle start pulse. It routes the loader's data stream and done pulse back to the granted channel only. It adds zero-count short-circuit and a stall watchdog with a per-channel error flag. It sits between the compute schedulers and the weight loader / DMA preload path.

## Interface
- `N_CH`, 2: number of requesting channels (≥2).
- `ADDR_W`, 32: weight base address width.
- `CNT_W`, 17: beat-count width.
- `DATA_W`, 128: data beat width.
- `RR_EN`, 1: 1 = round-robin, 0 = fixed priority (channel 0 highest).
- `TIMEOUT_CYC`, 4096: watchdog limit in idle loader cycles (≥2).

Ports:
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N_CH: per-channel request level. It is held until that channel's `done`.
- `base` in N_CH*ADDR_W: packed per-channel base address. Channel i is bits [i*ADDR_W +: ADDR_W].
- `count` in N_CH*CNT_W: packed per-channel beat count.
- `grant` out N_CH: one-hot, or zero when idle.
- `valid` out N_CH: per-channel data-valid pulse.
- `data` out DATA_W: shared data bus, qualified by `valid[i]`.
- `done` out N_CH: per-channel completion pulse.
- `err` out N_CH: timeout flag. It pulses together with `done[i]`.
- `busy` out 1: high while the FSM is not in IDLE.
- `ldr_start` out 1: one-cycle start pulse to the loader.
- `ldr_base` out ADDR_W: loader base address, held through the job.
- `ldr_count` out CNT_W: loader beat count, held through the job.
- `ldr_valid` in 1: loader data beat valid.
- `ldr_data` in DATA_W: loader data beat.
- `ldr_done` in 1: loader completion pulse.

## Operation
- FSM states:
  - IDLE → PICK when any `req` bit is set.
  - PICK → BUSY, or PICK → FIN when the selected count is 0.
  - BUSY → FIN on `ldr_done` or on watchdog expiry.
  - FIN → IDLE.
- IDLE:
  - `grant`=0.
  - Requests are sampled only in this state.
- PICK:
  - Selects the winner and registers `grant`, `ldr_base` and `ldr_count`.
  - If the count is non-zero, pulses `ldr_start` for exactly one cycle.
- Selection:
  - RR_EN=1: search starts at (last_winner+1) mod N_CH and wraps. last_winner resets to N_CH-1, so channel 0 wins first.
  - RR_EN=0: the lowest-index active request wins.
- BUSY:
  - Each `ldr_valid` is registered to `data` and to `valid[winner]`.
  - `ldr_done` moves the FSM to FIN.
  - `ldr_valid` and `ldr_done` in the same cycle: the beat is forwarded, then the FSM finishes.
- FIN:
  - Pulses `done[winner]`, plus `err[winner]` if the job timed out.
  - Clears `grant` and updates last_winner.
- Watchdog:
  - Counts cycles in BUSY and clears on every `ldr_valid`.
  - Reaching TIMEOUT_CYC forces FIN with `err`=1.
- Zero count: no `ldr_start` is issued. The job completes through FIN with `err`=0.
- Inputs outside BUSY: `ldr_valid` and `ldr_done` are ignored. This covers stale loader output after a timeout.
- A `req` bit dropping mid-job has no effect; the job completes.
- `base` and `count` are captured in PICK. Later changes are ignored.
- Reset in any state:
  - Next cycle is IDLE with all outputs 0.
  - last_winner = N_CH-1 and the watchdog is 0.
  - An in-flight loader job is abandoned; its beats fall under the outside-BUSY rule.

## Timing
- Reset values: `grant`, `valid`, `done`, `err`, `busy`, `ldr_start` are 0. `data`, `ldr_base`, `ldr_count` are 0.
- `req` high in IDLE at cycle t:
  - PICK at t+1, with `busy`=1.
  - `grant` and `ldr_start` high at t+2. BUSY from t+2.
- Data latency: `ldr_valid` at cycle c → `valid[i]` at c+1.
- Completion: `ldr_done` at cycle d → `done[i]` at d+1 (FIN), with `grant` low at d+2.
- Idle return: IDLE at d+2. The earliest next grant is d+4.
- Zero-count job: `grant` at t+2, `done` at t+3.
- Timeout: TIMEOUT_CYC cycles with no beat → `done`+`err` on the following cycle.
- Width rules:
  - The watchdog counter is $clog2(TIMEOUT_CYC+1) bits.
  - Counts pass through unmodified; there is no truncation.

## Structure
- Package `weight_arb_pkg` holds:
  - the state encoding (IDLE, PICK, BUSY, FIN);
  - the RR/FIXED mode constants;
  - a count-width helper function.
- Sub-module `rr_pick`:
  - Parametrised on N_CH.
  - Takes the request vector, last-winner index and mode; returns the one-hot winner and its index.
  - Purely combinational, registered by the parent.

## Test plan
- Single request, N_CH=2, RR_EN=1:
  - Stimulus: ch0 count=4, loader returns 4 beats A0..A3 then `ldr_done`.
  - Response: `valid[0]` ×4 with `data`=A0..A3, `valid[1]` never asserts, `done[0]` one pulse, `err`=0.
- Round-robin fairness, N_CH=4, RR_EN=1:
  - Stimulus: all `req` held, each count=1.
  - Response: grant order is 0,1,2,3,0.
- Fixed priority, RR_EN=0:
  - Stimulus: `req`=4'b1010 persistent.
  - Response: ch1 granted repeatedly, ch3 starved.
- Zero count:
  - Stimulus: ch1 count=0.
  - Response: no `ldr_start`, `done[1]` at t+3, `err[1]`=0.
- Watchdog:
  - Stimulus: TIMEOUT_CYC=16, loader sends 1 beat then stalls.
  - Response: `done`+`err` pulse 17 cycles after that beat. A late `ldr_done` is ignored.
- Reset mid-job:
  - Stimulus: assert `rst` during BUSY.
  - Response: all outputs 0 the next cycle. The first grant after reset goes to ch0.
